// File: rtl/debug_mem_access_ctrl_if.sv
// Port bundle for the debug memory access engine: debug-slave command side,
// Avalon-MM master side and the monitor readback signals.
interface debug_mem_access_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic [37:0]       jdo;
  logic              take_action_ocimem_a;
  logic              take_action_ocimem_b;
  logic              take_no_action_ocimem_a;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic              avm_write;
  logic [31:0]       avm_writedata;
  logic [3:0]        avm_byteenable;
  logic [31:0]       avm_readdata;
  logic              avm_waitrequest;
  logic [31:0]       MonDReg;
  logic              monitor_ready;
  logic              monitor_error;
  logic              busy;

  // The engine itself is the Avalon master and owns the monitor outputs.
  modport master (
    input  jdo, take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a,
    input  avm_readdata, avm_waitrequest,
    output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
    output MonDReg, monitor_ready, monitor_error, busy
  );

  modport slave (
    output jdo, take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a,
    output avm_readdata, avm_waitrequest,
    input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
    input  MonDReg, monitor_ready, monitor_error, busy
  );
endinterface

// File: rtl/debug_mem_access_ctrl.sv
// Debug memory access engine: decodes ocimem strobes and runs single-word
// Avalon-MM reads/writes with a stall timeout and a sticky error flag.
module debug_mem_access_ctrl #(
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  debug_mem_access_ctrl_if.master  bus
);
  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_mondreg;
  logic              r_ready;
  logic              r_error;
  logic [15:0]       r_tcnt;

  logic w_idle, w_sa, w_sb, w_sn;
  logic w_err_clr, w_req, w_done, w_tmo, w_ovr;
  logic w_go_read, w_go_write, w_load;
  logic w_avm_read, w_avm_write, w_busy;
  logic w_unused;

  assign w_unused = ^{bus.jdo[37], bus.jdo[2:0]};

  assign w_sa      = bus.take_action_ocimem_a;
  assign w_sb      = bus.take_action_ocimem_b;
  assign w_sn      = bus.take_no_action_ocimem_a;
  assign w_idle    = (r_state == IDLE);
  assign w_err_clr = w_sa & bus.jdo[36];
  assign w_req     = ~w_idle;
  assign w_done    = w_req & ~bus.avm_waitrequest;
  assign w_tmo     = w_req & bus.avm_waitrequest & (r_tcnt == TMO_LAST);

  // While busy, an error-clearing ocimem_a must not re-flag its own dropped command.
  always_comb begin
    w_ovr      = 1'b0;
    w_go_read  = 1'b0;
    w_go_write = 1'b0;
    w_load     = 1'b0;
    if (w_idle) begin
      w_ovr      = (w_sa & (w_sb | w_sn)) | (w_sb & w_sn);
      w_load     = w_sa & bus.jdo[35];
      w_go_read  = (w_sa & bus.jdo[34]) | (~w_sa & ~w_sb & w_sn);
      w_go_write = ~w_sa & w_sb;
    end else begin
      w_ovr = (w_sa & ~bus.jdo[36]) | w_sb | w_sn;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_go_read)       w_state_next = READ;
        else if (w_go_write) w_state_next = WRITE;
      end
      READ, WRITE: begin
        if (w_done || w_tmo) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_mondreg <= '0;
      r_ready   <= 1'b0;
      r_error   <= 1'b0;
      r_tcnt    <= '0;
    end else begin
      r_state <= w_state_next;

      if (w_load)      r_addr <= bus.jdo[17 +: ADDR_W];
      else if (w_done) r_addr <= r_addr + ADDR_W'(1);

      if (w_go_write) r_wdata <= bus.jdo[34:3];

      if (w_done && r_state == READ) r_mondreg <= bus.avm_readdata;

      if (w_go_read || w_go_write) r_ready <= 1'b0;
      else if (w_done || w_tmo)    r_ready <= 1'b1;

      if (w_go_read || w_go_write)          r_tcnt <= '0;
      else if (w_req && bus.avm_waitrequest) r_tcnt <= r_tcnt + 16'd1;

      r_error <= (r_error & ~w_err_clr) | w_ovr | w_tmo;
    end
  end

  always_comb begin
    w_avm_read  = (r_state == READ);
    w_avm_write = (r_state == WRITE);
    w_busy      = (r_state != IDLE);
  end

  assign bus.avm_address    = r_addr;
  assign bus.avm_read       = w_avm_read;
  assign bus.avm_write      = w_avm_write;
  assign bus.avm_writedata  = r_wdata;
  assign bus.avm_byteenable = 4'hF;
  assign bus.MonDReg        = r_mondreg;
  assign bus.monitor_ready  = r_ready;
  assign bus.monitor_error  = r_error;
  assign bus.busy           = w_busy;
endmodule

// File: tb/tb_debug_mem_access_ctrl.sv
// Directed bench for debug_mem_access_ctrl with TIMEOUT_CYCLES=4; the slave
// side (waitrequest/readdata) is driven directly by each scenario task.
module tb_debug_mem_access_ctrl;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  debug_mem_access_ctrl_if #(.ADDR_W(8)) bus ();

  debug_mem_access_ctrl #(.ADDR_W(8), .TIMEOUT_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [37:0] mk_a(input logic clr, input logic ld, input logic rd,
                                       input logic [7:0] addr);
    logic [37:0] j;
    j = '0;
    j[36] = clr;
    j[35] = ld;
    j[34] = rd;
    j[17 +: 8] = addr;
    return j;
  endfunction

  function automatic logic [37:0] mk_b(input logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[34:3] = d;
    return j;
  endfunction

  task automatic strobe(input logic sa, input logic sb, input logic sn, input logic [37:0] j);
    bus.jdo = j;
    bus.take_action_ocimem_a = sa;
    bus.take_action_ocimem_b = sb;
    bus.take_no_action_ocimem_a = sn;
    tick();
    bus.take_action_ocimem_a = 1'b0;
    bus.take_action_ocimem_b = 1'b0;
    bus.take_no_action_ocimem_a = 1'b0;
    bus.jdo = 38'h3F_FFFF_FFFF;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_cmp++; if (bus.avm_address !== 8'h00) begin n_bad++; $display("FAIL rst_addr: got %h want 00", bus.avm_address); end
    n_cmp++; if (bus.avm_read !== 1'b0 || bus.avm_write !== 1'b0) begin n_bad++; $display("FAIL rst_req: got rd=%b wr=%b want 0/0", bus.avm_read, bus.avm_write); end
    n_cmp++; if (bus.avm_writedata !== 32'h0) begin n_bad++; $display("FAIL rst_wdata: got %h want 0", bus.avm_writedata); end
    n_cmp++; if (bus.MonDReg !== 32'h0) begin n_bad++; $display("FAIL rst_mondreg: got %h want 0", bus.MonDReg); end
    n_cmp++; if ({bus.monitor_ready, bus.monitor_error, bus.busy} !== 3'b000) begin n_bad++; $display("FAIL rst_flags: got rdy/err/busy=%b%b%b want 000", bus.monitor_ready, bus.monitor_error, bus.busy); end
    n_cmp++; if (bus.avm_byteenable !== 4'hF) begin n_bad++; $display("FAIL rst_be: got %h want F", bus.avm_byteenable); end
  endtask

  task automatic test_zero_wait_read();
    bus.avm_waitrequest = 1'b0;
    bus.avm_readdata = 32'hCAFE_F00D;
    strobe(1'b1, 1'b0, 1'b0, mk_a(1'b0, 1'b1, 1'b1, 8'h10));
    n_cmp++; if (bus.avm_read !== 1'b1 || bus.avm_address !== 8'h10) begin n_bad++; $display("FAIL zw_req: got rd=%b addr=%h want 1/10", bus.avm_read, bus.avm_address); end
    n_cmp++; if (bus.busy !== 1'b1 || bus.monitor_ready !== 1'b0) begin n_bad++; $display("FAIL zw_busy: got busy=%b rdy=%b want 1/0", bus.busy, bus.monitor_ready); end
    tick();
    bus.avm_readdata = 32'h0;
    n_cmp++; if (bus.MonDReg !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL zw_data: got %h want CAFEF00D", bus.MonDReg); end
    n_cmp++; if (bus.monitor_ready !== 1'b1 || bus.busy !== 1'b0 || bus.avm_read !== 1'b0) begin n_bad++; $display("FAIL zw_done: got rdy=%b busy=%b rd=%b want 1/0/0", bus.monitor_ready, bus.busy, bus.avm_read); end
    n_cmp++; if (bus.avm_address !== 8'h11) begin n_bad++; $display("FAIL zw_addr_inc: got %h want 11", bus.avm_address); end
  endtask

  task automatic test_stalled_write();
    bus.avm_waitrequest = 1'b1;
    strobe(1'b0, 1'b1, 1'b0, mk_b(32'h1234_5678));
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (bus.avm_write !== 1'b1 || bus.avm_writedata !== 32'h1234_5678 || bus.avm_address !== 8'h11) begin n_bad++; $display("FAIL sw_stall%0d: got wr=%b d=%h a=%h want 1/12345678/11", i, bus.avm_write, bus.avm_writedata, bus.avm_address); end
      tick();
    end
    bus.avm_waitrequest = 1'b0;
    n_cmp++; if (bus.avm_write !== 1'b1) begin n_bad++; $display("FAIL sw_4th: got wr=%b want 1", bus.avm_write); end
    tick();
    n_cmp++; if ({bus.avm_write, bus.busy, bus.monitor_ready, bus.monitor_error} !== 4'b0010) begin n_bad++; $display("FAIL sw_done: got wr/busy/rdy/err=%b%b%b%b want 0010", bus.avm_write, bus.busy, bus.monitor_ready, bus.monitor_error); end
    n_cmp++; if (bus.avm_address !== 8'h12) begin n_bad++; $display("FAIL sw_addr_inc: got %h want 12", bus.avm_address); end
  endtask

  task automatic test_stream_wrap();
    strobe(1'b1, 1'b0, 1'b0, mk_a(1'b0, 1'b1, 1'b0, 8'hFF));
    n_cmp++; if (bus.avm_address !== 8'hFF || bus.busy !== 1'b0) begin n_bad++; $display("FAIL wr_load: got a=%h busy=%b want FF/0", bus.avm_address, bus.busy); end
    bus.avm_waitrequest = 1'b0;
    bus.avm_readdata = 32'h1111_1111;
    strobe(1'b0, 1'b0, 1'b1, 38'h0);
    n_cmp++; if (bus.avm_read !== 1'b1 || bus.avm_address !== 8'hFF) begin n_bad++; $display("FAIL wr_rd1: got rd=%b a=%h want 1/FF", bus.avm_read, bus.avm_address); end
    tick();
    n_cmp++; if (bus.MonDReg !== 32'h1111_1111 || bus.avm_address !== 8'h00) begin n_bad++; $display("FAIL wr_wrap: got d=%h a=%h want 11111111/00", bus.MonDReg, bus.avm_address); end
    bus.avm_readdata = 32'h2222_2222;
    strobe(1'b0, 1'b0, 1'b1, 38'h0);
    n_cmp++; if (bus.avm_read !== 1'b1 || bus.avm_address !== 8'h00) begin n_bad++; $display("FAIL wr_rd2: got rd=%b a=%h want 1/00", bus.avm_read, bus.avm_address); end
    tick();
    n_cmp++; if (bus.MonDReg !== 32'h2222_2222 || bus.avm_address !== 8'h01) begin n_bad++; $display("FAIL wr_after: got d=%h a=%h want 22222222/01", bus.MonDReg, bus.avm_address); end
  endtask

  task automatic test_timeout();
    bus.avm_waitrequest = 1'b1;
    bus.avm_readdata = 32'hDEAD_BEEF;
    strobe(1'b0, 1'b0, 1'b1, 38'h0);
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (bus.avm_read !== 1'b1 || bus.monitor_error !== 1'b0) begin n_bad++; $display("FAIL to_stall%0d: got rd=%b err=%b want 1/0", i, bus.avm_read, bus.monitor_error); end
      tick();
    end
    n_cmp++; if ({bus.avm_read, bus.busy, bus.monitor_ready, bus.monitor_error} !== 4'b0011) begin n_bad++; $display("FAIL to_abort: got rd/busy/rdy/err=%b%b%b%b want 0011", bus.avm_read, bus.busy, bus.monitor_ready, bus.monitor_error); end
    n_cmp++; if (bus.MonDReg !== 32'h2222_2222 || bus.avm_address !== 8'h01) begin n_bad++; $display("FAIL to_keep: got d=%h a=%h want 22222222/01", bus.MonDReg, bus.avm_address); end
    bus.avm_waitrequest = 1'b0;
    strobe(1'b1, 1'b0, 1'b0, mk_a(1'b1, 1'b0, 1'b0, 8'h00));
    n_cmp++; if (bus.monitor_error !== 1'b0 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL to_clear: got err=%b busy=%b want 0/0", bus.monitor_error, bus.busy); end
  endtask

  task automatic test_overrun_priority();
    bus.avm_waitrequest = 1'b1;
    strobe(1'b0, 1'b1, 1'b0, mk_b(32'hAAAA_5555));
    strobe(1'b0, 1'b1, 1'b0, mk_b(32'h0BAD_F00D));
    n_cmp++; if (bus.monitor_error !== 1'b1 || bus.avm_writedata !== 32'hAAAA_5555 || bus.avm_write !== 1'b1) begin n_bad++; $display("FAIL ov_drop: got err=%b d=%h wr=%b want 1/AAAA5555/1", bus.monitor_error, bus.avm_writedata, bus.avm_write); end
    bus.avm_waitrequest = 1'b0;
    tick();
    n_cmp++; if (bus.busy !== 1'b0 || bus.monitor_ready !== 1'b1 || bus.monitor_error !== 1'b1) begin n_bad++; $display("FAIL ov_sticky: got busy=%b rdy=%b err=%b want 0/1/1", bus.busy, bus.monitor_ready, bus.monitor_error); end
    // error clear while busy: clear applies, the dropped read does not re-flag
    bus.avm_waitrequest = 1'b1;
    strobe(1'b0, 1'b0, 1'b1, 38'h0);
    strobe(1'b1, 1'b0, 1'b0, mk_a(1'b1, 1'b0, 1'b1, 8'h00));
    n_cmp++; if (bus.monitor_error !== 1'b0 || bus.busy !== 1'b1 || bus.avm_address !== 8'h02) begin n_bad++; $display("FAIL ov_busy_clr: got err=%b busy=%b a=%h want 0/1/02", bus.monitor_error, bus.busy, bus.avm_address); end
    bus.avm_waitrequest = 1'b0;
    tick();
    bus.avm_readdata = 32'h5A5A_5A5A;
    strobe(1'b1, 1'b1, 1'b0, mk_a(1'b0, 1'b0, 1'b1, 8'h00));
    n_cmp++; if (bus.avm_read !== 1'b1 || bus.avm_write !== 1'b0 || bus.monitor_error !== 1'b1 || bus.avm_address !== 8'h03) begin n_bad++; $display("FAIL pr_win: got rd=%b wr=%b err=%b a=%h want 1/0/1/03", bus.avm_read, bus.avm_write, bus.monitor_error, bus.avm_address); end
    tick();
    n_cmp++; if (bus.MonDReg !== 32'h5A5A_5A5A || bus.avm_writedata !== 32'hAAAA_5555) begin n_bad++; $display("FAIL pr_result: got d=%h wd=%h want 5A5A5A5A/AAAA5555", bus.MonDReg, bus.avm_writedata); end
    strobe(1'b1, 1'b0, 1'b0, mk_a(1'b1, 1'b0, 1'b0, 8'h00));
  endtask

  task automatic test_back_to_back();
    bus.avm_waitrequest = 1'b0;
    bus.avm_readdata = 32'h0101_0101;
    strobe(1'b0, 1'b0, 1'b1, 38'h0);
    tick();
    n_cmp++; if (bus.busy !== 1'b0 || bus.MonDReg !== 32'h0101_0101) begin n_bad++; $display("FAIL bb_first: got busy=%b d=%h want 0/01010101", bus.busy, bus.MonDReg); end
    bus.avm_readdata = 32'h0202_0202;
    strobe(1'b0, 1'b0, 1'b1, 38'h0);
    n_cmp++; if (bus.avm_read !== 1'b1 || bus.avm_address !== 8'h05 || bus.monitor_error !== 1'b0) begin n_bad++; $display("FAIL bb_accept: got rd=%b a=%h err=%b want 1/05/0", bus.avm_read, bus.avm_address, bus.monitor_error); end
    tick();
    n_cmp++; if (bus.MonDReg !== 32'h0202_0202 || bus.avm_address !== 8'h06) begin n_bad++; $display("FAIL bb_second: got d=%h a=%h want 02020202/06", bus.MonDReg, bus.avm_address); end
  endtask

  task automatic test_reset_mid_access();
    bus.avm_waitrequest = 1'b1;
    strobe(1'b0, 1'b0, 1'b1, 38'h0);
    n_cmp++; if (bus.avm_read !== 1'b1) begin n_bad++; $display("FAIL rm_start: got rd=%b want 1", bus.avm_read); end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++; if ({bus.avm_read, bus.busy, bus.monitor_ready} !== 3'b000) begin n_bad++; $display("FAIL rm_flags: got rd/busy/rdy=%b%b%b want 000", bus.avm_read, bus.busy, bus.monitor_ready); end
    n_cmp++; if (bus.MonDReg !== 32'h0 || bus.avm_address !== 8'h00) begin n_bad++; $display("FAIL rm_state: got d=%h a=%h want 0/00", bus.MonDReg, bus.avm_address); end
    tick();
    n_cmp++; if (bus.busy !== 1'b0 || bus.monitor_ready !== 1'b0) begin n_bad++; $display("FAIL rm_after: got busy=%b rdy=%b want 0/0", bus.busy, bus.monitor_ready); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    bus.jdo = '0;
    bus.take_action_ocimem_a = 1'b0;
    bus.take_action_ocimem_b = 1'b0;
    bus.take_no_action_ocimem_a = 1'b0;
    bus.avm_readdata = '0;
    bus.avm_waitrequest = 1'b0;
    test_reset();
    test_zero_wait_read();
    test_stalled_write();
    test_stream_wrap();
    test_timeout();
    test_overrun_priority();
    test_back_to_back();
    test_reset_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
